// File: rtl/cmp_rr_sched_if.sv
// rtl/cmp_rr_sched_if.sv - requester, comparator and response signals of the shared-comparator scheduler
interface cmp_rr_sched_if #(
    parameter int W = 3
);
    logic         req0_valid;
    logic [W-1:0] req0_a;
    logic [W-1:0] req0_b;
    logic         req0_ready;
    logic         req1_valid;
    logic [W-1:0] req1_a;
    logic [W-1:0] req1_b;
    logic         req1_ready;
    logic [W-1:0] cmp_a;
    logic [W-1:0] cmp_b;
    logic         cmp_gt;
    logic         cmp_eq;
    logic         cmp_lt;
    logic         rsp_valid;
    logic         rsp_ready;
    logic         rsp_id;
    logic         rsp_gt;
    logic         rsp_eq;
    logic         rsp_lt;
    logic         err;
    logic [7:0]   done_count;

    modport slave (
        input  req0_valid, req0_a, req0_b,
        input  req1_valid, req1_a, req1_b,
        input  cmp_gt, cmp_eq, cmp_lt,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output cmp_a, cmp_b,
        output rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt,
        output err, done_count
    );

    modport master (
        output req0_valid, req0_a, req0_b,
        output req1_valid, req1_a, req1_b,
        output cmp_gt, cmp_eq, cmp_lt,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  cmp_a, cmp_b,
        input  rsp_valid, rsp_id, rsp_gt, rsp_eq, rsp_lt,
        input  err, done_count
    );
endinterface

// File: rtl/cmp_rr_sched.sv
// rtl/cmp_rr_sched.sv - round-robin scheduler sharing one external comparator between two requesters
module cmp_rr_sched #(
    parameter int W      = 3,
    parameter int SETTLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    cmp_rr_sched_if.slave   bus
);
    localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        RESP
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           last_grant_q, last_grant_d;
    logic           pend_id_q, pend_id_d;
    logic [W-1:0]   cmp_a_q, cmp_a_d;
    logic [W-1:0]   cmp_b_q, cmp_b_d;
    logic           rsp_valid_q, rsp_valid_d;
    logic           rsp_id_q, rsp_id_d;
    logic           rsp_gt_q, rsp_gt_d;
    logic           rsp_eq_q, rsp_eq_d;
    logic           rsp_lt_q, rsp_lt_d;
    logic           err_q, err_d;
    logic [7:0]     done_count_q, done_count_d;

    logic           sel_valid;
    logic           sel_id;
    logic           ready0;
    logic           ready1;
    logic           hs;
    logic           flags_ok;

    // Arbiter: a lone requester wins outright, contention goes to the one not served last
    always_comb begin
        sel_valid = bus.req0_valid | bus.req1_valid;
        sel_id    = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            sel_id = ~last_grant_q;
        end else if (bus.req1_valid) begin
            sel_id = 1'b1;
        end
        ready0   = (state_q == IDLE) && !rst && sel_valid && !sel_id;
        ready1   = (state_q == IDLE) && !rst && sel_valid && sel_id;
        hs       = ready0 | ready1;
        // exactly one flag set: odd parity and not all three
        flags_ok = (bus.cmp_gt ^ bus.cmp_eq ^ bus.cmp_lt) & ~(bus.cmp_gt & bus.cmp_eq & bus.cmp_lt);
    end

    // Next-state and datapath: accept in IDLE, hold operands for SETTLE cycles, sample, then wait for consumer
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        pend_id_d    = pend_id_q;
        cmp_a_d      = cmp_a_q;
        cmp_b_d      = cmp_b_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_id_d     = rsp_id_q;
        rsp_gt_d     = rsp_gt_q;
        rsp_eq_d     = rsp_eq_q;
        rsp_lt_d     = rsp_lt_q;
        err_d        = err_q;
        done_count_d = done_count_q;
        case (state_q)
            IDLE: begin
                if (hs) begin
                    cmp_a_d      = sel_id ? bus.req1_a : bus.req0_a;
                    cmp_b_d      = sel_id ? bus.req1_b : bus.req0_b;
                    pend_id_d    = sel_id;
                    last_grant_d = sel_id;
                    cnt_d        = '0;
                    state_d      = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == CW'(SETTLE - 1)) begin
                    rsp_gt_d    = bus.cmp_gt;
                    rsp_eq_d    = bus.cmp_eq;
                    rsp_lt_d    = bus.cmp_lt;
                    rsp_id_d    = pend_id_q;
                    rsp_valid_d = 1'b1;
                    if (!flags_ok) begin
                        err_d = 1'b1;
                    end
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    rsp_valid_d  = 1'b0;
                    done_count_d = done_count_q + 8'd1;
                    state_d      = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register with synchronous reset; last_grant resets to 1 so requester 0 wins first contention
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            last_grant_q <= 1'b1;
            pend_id_q    <= 1'b0;
            cmp_a_q      <= '0;
            cmp_b_q      <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= 1'b0;
            rsp_gt_q     <= 1'b0;
            rsp_eq_q     <= 1'b0;
            rsp_lt_q     <= 1'b0;
            err_q        <= 1'b0;
            done_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            pend_id_q    <= pend_id_d;
            cmp_a_q      <= cmp_a_d;
            cmp_b_q      <= cmp_b_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_id_q     <= rsp_id_d;
            rsp_gt_q     <= rsp_gt_d;
            rsp_eq_q     <= rsp_eq_d;
            rsp_lt_q     <= rsp_lt_d;
            err_q        <= err_d;
            done_count_q <= done_count_d;
        end
    end

    assign bus.req0_ready = ready0;
    assign bus.req1_ready = ready1;
    assign bus.cmp_a      = cmp_a_q;
    assign bus.cmp_b      = cmp_b_q;
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_gt     = rsp_gt_q;
    assign bus.rsp_eq     = rsp_eq_q;
    assign bus.rsp_lt     = rsp_lt_q;
    assign bus.err        = err_q;
    assign bus.done_count = done_count_q;
endmodule

// File: tb/tb_cmp_rr_sched.sv
// tb/tb_cmp_rr_sched.sv - bench for cmp_rr_sched with a transaction model and directed vectors
module tb_cmp_rr_sched;
    localparam int W      = 3;
    localparam int SETTLE = 1;

    logic clk   = 1'b0;
    logic rst   = 1'b1;
    logic fault = 1'b0;
    int   checks = 0;
    int   errors = 0;

    cmp_rr_sched_if #(.W(W)) bus ();

    cmp_rr_sched #(.W(W), .SETTLE(SETTLE)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    // External comparator; fault forces the illegal gt+lt pattern
    always_comb begin
        if (fault) begin
            bus.cmp_gt = 1'b1;
            bus.cmp_eq = 1'b0;
            bus.cmp_lt = 1'b1;
        end else begin
            bus.cmp_gt = (bus.cmp_a > bus.cmp_b);
            bus.cmp_eq = (bus.cmp_a == bus.cmp_b);
            bus.cmp_lt = (bus.cmp_a < bus.cmp_b);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: an operation accepted in cycle c answers in cycle c+1+SETTLE
    int          cyc = 0;
    bit          m_on = 0;
    bit          m_inflight = 0;
    int          m_due = 0;
    bit          m_out = 0;
    bit          m_last = 1;
    int          m_ca = 0;
    int          m_cb = 0;
    bit          m_id = 0;
    bit          m_gt = 0;
    bit          m_eq = 0;
    bit          m_lt = 0;
    bit          m_err = 0;
    int          m_done = 0;

    always @(negedge clk) begin
        bit v0, v1, free, pick, e_r0, e_r1;
        int a, b;
        v0 = bus.req0_valid;
        v1 = bus.req1_valid;
        if (m_on) begin
            if (m_inflight && cyc == m_due) begin
                m_inflight = 0;
                m_out      = 1;
                if (int'(m_gt) + int'(m_eq) + int'(m_lt) != 1) m_err = 1;
            end
        end
        free = !m_inflight && !m_out && !rst;
        pick = (v0 && v1) ? !m_last : v1;
        e_r0 = m_on && free && (v0 || v1) && !pick;
        e_r1 = m_on && free && (v0 || v1) && pick;
        if (m_on) begin
            check("m_req0_ready", bus.req0_ready, e_r0);
            check("m_req1_ready", bus.req1_ready, e_r1);
            check("m_rsp_valid", bus.rsp_valid, m_out);
            check("m_err", bus.err, m_err);
            check("m_done_count", bus.done_count, m_done);
            check("m_cmp_a", bus.cmp_a, m_ca);
            check("m_cmp_b", bus.cmp_b, m_cb);
            if (m_out) begin
                check("m_rsp_id", bus.rsp_id, m_id);
                check("m_rsp_flags", {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, {m_gt, m_eq, m_lt});
            end
        end
        if (rst) begin
            m_on = 1; m_inflight = 0; m_out = 0; m_last = 1;
            m_ca = 0; m_cb = 0; m_err = 0; m_done = 0;
        end else if (m_on) begin
            if (m_out && bus.rsp_ready) begin
                m_out  = 0;
                m_done = (m_done + 1) % 256;
            end
            if ((e_r0 && v0) || (e_r1 && v1)) begin
                m_id = e_r1;
                a = e_r1 ? int'(bus.req1_a) : int'(bus.req0_a);
                b = e_r1 ? int'(bus.req1_b) : int'(bus.req0_b);
                m_ca = a;
                m_cb = b;
                m_last = m_id;
                m_inflight = 1;
                m_due = cyc + 1 + SETTLE;
                if (fault) begin
                    m_gt = 1; m_eq = 0; m_lt = 1;
                end else begin
                    m_gt = (a > b); m_eq = (a == b); m_lt = (a < b);
                end
            end
        end
        cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // One complete operation for requester id with rsp_ready held high
    task automatic run_op(input bit id, input logic [W-1:0] a, input logic [W-1:0] b);
        int n;
        bus.rsp_ready = 1'b1;
        if (id) begin
            bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
        end else begin
            bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
        end
        #1;
        n = 0;
        while (!(id ? bus.req1_ready : bus.req0_ready) && n < 20) begin
            tick(); #1; n++;
        end
        check("op_grant_timeout", id ? bus.req1_ready : bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        n = 0;
        while (!bus.rsp_valid && n < 20) begin
            tick(); #1; n++;
        end
        check("op_rsp_timeout", bus.rsp_valid, 1);
        tick();
    endtask

    initial begin
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.rsp_ready  = 1'b0;

        // Reset: readys low while rst is high, outputs cleared
        rst = 1'b1;
        bus.req0_valid = 1'b1;
        #1;
        check("rst_ready0_low", bus.req0_ready, 0);
        tick();
        rst = 1'b0;
        bus.req0_valid = 1'b0;
        check("rst_rsp_valid", bus.rsp_valid, 0);
        check("rst_done_count", bus.done_count, 0);
        check("rst_err", bus.err, 0);
        check("rst_cmp_a", bus.cmp_a, 0);

        // Single request 6 vs 1: response two cycles after the handshake
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 3'd6; bus.req0_b = 3'd1;
        #1;
        check("t1_ready0", bus.req0_ready, 1);
        tick();
        bus.req0_valid = 1'b0;
        #1;
        check("t1_not_yet_valid", bus.rsp_valid, 0);
        tick();
        check("t1_rsp_valid", bus.rsp_valid, 1);
        check("t1_rsp_id", bus.rsp_id, 0);
        check("t1_flags", {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, 3'b100);
        tick();
        check("t1_done_count", bus.done_count, 1);
        check("t1_rsp_dropped", bus.rsp_valid, 0);

        // Contention out of reset: req0 first, then req1, then req0 again
        do_reset();
        bus.rsp_ready = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 3'd2; bus.req0_b = 3'd3;
        bus.req1_valid = 1'b1; bus.req1_a = 3'd5; bus.req1_b = 3'd4;
        #1;
        check("t2_first_ready0", bus.req0_ready, 1);
        check("t2_first_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        tick();
        check("t2_rsp0_id", bus.rsp_id, 0);
        check("t2_rsp0_flags", {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, 3'b001);
        tick();
        #1;
        check("t2_second_ready1", bus.req1_ready, 1);
        tick();
        bus.req1_valid = 1'b0;
        tick();
        check("t2_rsp1_id", bus.rsp_id, 1);
        check("t2_rsp1_flags", {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, 3'b100);
        tick();
        bus.req0_valid = 1'b1; bus.req0_a = 3'd7; bus.req0_b = 3'd7;
        bus.req1_valid = 1'b1; bus.req1_a = 3'd0; bus.req1_b = 3'd1;
        #1;
        check("t2_alt_ready0", bus.req0_ready, 1);
        check("t2_alt_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        tick();
        check("t2_done_count", bus.done_count, 3);

        // Backpressure: response held for several cycles while req0 waits
        bus.rsp_ready = 1'b0;
        bus.req1_valid = 1'b1; bus.req1_a = 3'd3; bus.req1_b = 3'd3;
        tick();
        bus.req1_valid = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_a = 3'd1; bus.req0_b = 3'd2;
        tick();
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t3_hold_valid", bus.rsp_valid, 1);
            check("t3_hold_id", bus.rsp_id, 1);
            check("t3_hold_flags", {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, 3'b010);
            check("t3_hold_ready0", bus.req0_ready, 0);
            check("t3_hold_ready1", bus.req1_ready, 0);
            check("t3_hold_done", bus.done_count, 3);
            tick();
        end
        bus.rsp_ready = 1'b1;
        tick();
        bus.req0_valid = 1'b0;
        check("t3_done_once", bus.done_count, 4);
        check("t3_rsp_dropped", bus.rsp_valid, 0);
        tick();
        check("t3_done_stays", bus.done_count, 4);

        // Faulty comparator: flags delivered as sampled, err sticky until rst
        fault = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = 3'd1; bus.req0_b = 3'd2;
        tick();
        bus.req0_valid = 1'b0;
        tick();
        check("t4_fault_flags", {bus.rsp_gt, bus.rsp_eq, bus.rsp_lt}, 3'b101);
        check("t4_err_set", bus.err, 1);
        tick();
        fault = 1'b0;
        run_op(1'b1, 3'd4, 3'd4);
        run_op(1'b0, 3'd0, 3'd5);
        check("t4_err_sticky", bus.err, 1);
        do_reset();
        check("t4_err_cleared", bus.err, 0);

        // Mid-operation reset drops the pending op and restores the grant pointer
        run_op(1'b0, 3'd5, 3'd2);
        check("t5_done_before", bus.done_count, 1);
        bus.req0_valid = 1'b1; bus.req0_a = 3'd7; bus.req0_b = 3'd0;
        tick();
        bus.req0_valid = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("t5_no_rsp", bus.rsp_valid, 0);
            check("t5_done_zero", bus.done_count, 0);
            tick();
        end
        bus.req0_valid = 1'b1; bus.req0_a = 3'd3; bus.req0_b = 3'd6;
        bus.req1_valid = 1'b1; bus.req1_a = 3'd6; bus.req1_b = 3'd3;
        #1;
        check("t5_ready0", bus.req0_ready, 1);
        check("t5_ready1", bus.req1_ready, 0);
        tick();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        tick();
        tick();

        // Wrap: 256 completed operations bring done_count back to 0
        do_reset();
        for (int i = 0; i < 256; i++) begin
            run_op(i[0], W'($urandom_range(0, 7)), W'($urandom_range(0, 7)));
            if (i == 254) check("t6_done_255", bus.done_count, 255);
        end
        check("t6_done_wrap", bus.done_count, 0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
